uart_reg_bridge: RTL
====================

Name: uart_reg_bridge

Overview:
Command parser that sits directly downstream of the UART receiver and upstream of the UART transmitter. It consumes received bytes (rx_valid/rx_data), decodes 2- or 3-byte read/write frames and drives a simple single-cycle register bus. It returns a response byte (read data, ACK or NAK) through the transmitter's wr_en/tx_busy handshake.

Parameters:
ACK_BYTE, 8'h4B, byte sent after a completed write ('K')
NAK_BYTE, 8'h3F, byte sent after an unknown command byte ('?')
RD_LATENCY, 1, cycles from reg_rd pulse to reg_rdata valid (1..4)
TIMEOUT_CYC, 21700, idle cycles before a partial frame is aborted (timeout feature only)

Ports:
clk  in  1  system clock
rstb  in  1  reset; synchronous, active-high (1 = reset)
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received byte
tx_wr_en  out  1  one-cycle strobe to transmitter, tx_data valid
tx_data  out  8  byte to transmit
tx_busy  in  1  transmitter busy; goes high the cycle after tx_wr_en
reg_wr  out  1  one-cycle register write strobe
reg_rd  out  1  one-cycle register read strobe
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_rdata  in  8  register read data, valid RD_LATENCY cycles after reg_rd
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Frame format: write = 0x57 ('W'), addr, data. Read = 0x52 ('R'), addr.
- Reset (rstb=1 at clk edge): FSM -> IDLE. All outputs 0: tx_wr_en, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, busy. Latency counter and timeout counter are cleared. Reset mid-frame or mid-response discards everything; no response byte is sent.
- States: IDLE, GET_ADDR, GET_DATA, DO_WR, DO_RD, RD_WAIT, SEND, SEND_HOLD, SEND_WAIT.
- IDLE:
  - rx_valid with 'W' or 'R' -> GET_ADDR; the command is latched.
  - Any other byte: tx_data <= NAK_BYTE -> SEND.
- GET_ADDR, on rx_valid: reg_addr <= rx_data.
  - Write command -> GET_DATA.
  - Read command -> DO_RD.
- GET_DATA, on rx_valid: reg_wdata <= rx_data -> DO_WR.
- DO_WR: reg_wr=1 for exactly one cycle; tx_data <= ACK_BYTE -> SEND.
- DO_RD: reg_rd=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles after the reg_rd cycle. On the final count, tx_data <= reg_rdata -> SEND.
- SEND: if tx_busy==0, tx_wr_en=1 for one cycle -> SEND_HOLD. Otherwise stay in SEND.
- SEND_HOLD: one cycle; tx_busy is ignored -> SEND_WAIT.
- SEND_WAIT: on tx_busy==0 -> IDLE.
- Write-to-ACK latency: reg_wr is asserted in the cycle after the data-byte rx_valid. tx_wr_en is asserted 2 cycles after that data-byte rx_valid when tx is idle.
- rx_valid in DO_WR, DO_RD, RD_WAIT, SEND, SEND_HOLD or SEND_WAIT: the byte is dropped; no state change.
- reg_addr and reg_wdata hold their values until overwritten by a later frame.
- reg_wr and reg_rd are never high in the same cycle.
- busy = (state != IDLE), registered.
- Back-to-back frames: the next command byte is accepted in IDLE only, i.e. the cycle after SEND_WAIT sees tx_busy==0.

Optional Feature:
UART_REG_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs in GET_ADDR and GET_DATA and clears on every rx_valid.
  - When it reaches TIMEOUT_CYC-1 with no byte, the FSM returns to IDLE silently (no NAK). Strobes stay 0 and reg_addr/reg_wdata keep their values.
- Undefined: no counter exists; a partial frame waits indefinitely.

Decomposition:
- Package uart_reg_pkg holds:
  - State enum typedef.
  - Command constants CMD_WR=8'h57, CMD_RD=8'h52.
  - Default ACK/NAK byte constants.
- No sub-module: a single FSM with latency and timeout counters. Transmitter and receiver are instantiated alongside it at the top level, not inside it.

Test Plan:
- Bytes 0x57,0x10,0xA5 -> one reg_wr pulse with reg_addr=0x10, reg_wdata=0xA5, then one tx_wr_en with tx_data=0x4B; reg_rd never high.
- Bytes 0x52,0x20 with reg_rdata model returning 0x3C, RD_LATENCY=1 -> one reg_rd pulse with addr 0x20, then tx_wr_en with tx_data=0x3C.
- Byte 0x00 -> tx_wr_en with tx_data=0x3F; no reg strobes. A following 0x52,0x01 frame completes normally.
- tx_busy held high 100 cycles at the moment the response is ready -> tx_wr_en withheld until tx_busy falls, then exactly one pulse. An rx_valid byte injected during SEND_WAIT is ignored.
- rstb pulsed after 0x57,0x10 -> no reg_wr, no tx_wr_en, busy=0. A new 0x52,0x05 frame is decoded correctly.
- With UART_REG_TIMEOUT_EN and TIMEOUT_CYC=50: 0x57 then 60 idle cycles -> IDLE, no response. A subsequent full write frame is ACKed. Without the macro, the same stimulus leaves busy=1.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// Shared types and constants for the UART register bridge.
package uart_reg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StDoWr,
    StDoRd,
    StRdWait,
    StSend,
    StSendHold,
    StSendWait
  } state_e;

  localparam logic [7:0] CMD_WR       = 8'h57;
  localparam logic [7:0] CMD_RD       = 8'h52;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h4B;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h3F;

endpackage

// File: rtl/uart_reg_bridge.sv
// UART byte-stream to register-bus bridge: decodes 'W' addr data / 'R' addr frames.
// Define UART_REG_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module uart_reg_bridge
  import uart_reg_pkg::*;
#(
  parameter logic [7:0]  ACK_BYTE   = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE   = NAK_BYTE_DEF,
  parameter int unsigned RD_LATENCY = 1
`ifdef UART_REG_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 21700
`endif
) (
  input  logic       clk_i,
  input  logic       rstb_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       tx_wr_en_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_busy_i,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  state_e     state_q, state_d;
  logic       cmd_wr_q, cmd_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [2:0] lat_q, lat_d;
`ifdef UART_REG_TIMEOUT_EN
  logic [15:0] to_q, to_d;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_wr_d  = cmd_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    lat_d     = lat_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
            cmd_wr_d = (rx_data_i == CMD_WR);
            state_d  = StGetAddr;
          end else begin
            tx_data_d = NAK_BYTE;
            state_d   = StSend;
          end
        end
      end
      StGetAddr: begin
        if (rx_valid_i) begin
          addr_d  = rx_data_i;
          state_d = cmd_wr_q ? StGetData : StDoRd;
        end
      end
      StGetData: begin
        if (rx_valid_i) begin
          wdata_d = rx_data_i;
          state_d = StDoWr;
        end
      end
      StDoWr: begin
        tx_data_d = ACK_BYTE;
        state_d   = StSend;
      end
      StDoRd: begin
        lat_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        // lat_q counts cycles since the reg_rd strobe; rdata is valid on the last one
        if (lat_q == 3'(RD_LATENCY - 1)) begin
          tx_data_d = reg_rdata_i;
          state_d   = StSend;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StSend:     if (!tx_busy_i) state_d = StSendHold;
      StSendHold: state_d = StSendWait;
      StSendWait: if (!tx_busy_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase

`ifdef UART_REG_TIMEOUT_EN
    to_d = '0;
    if ((state_q == StGetAddr || state_q == StGetData) && !rx_valid_i) begin
      if (to_q == 16'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
      end else begin
        to_d = to_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rstb_i) begin
      state_q   <= StIdle;
      cmd_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      lat_q     <= '0;
`ifdef UART_REG_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_wr_q  <= cmd_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      lat_q     <= lat_d;
`ifdef UART_REG_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign reg_wr_o    = (state_q == StDoWr);
  assign reg_rd_o    = (state_q == StDoRd);
  assign tx_wr_en_o  = (state_q == StSend) && !tx_busy_i;
  assign tx_data_o   = tx_data_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule
